// File: rtl/cat_trap_game_fsm_pkg.sv
// rtl/cat_trap_game_fsm_pkg.sv - shared types and constants for the CatTrap game-logic stage
package cat_trap_pkg;

    localparam int MAX_N = 16;
    localparam int IDX_W = $clog2(MAX_N);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_PLAYER = 3'd1;
    localparam logic [2:0] ST_CAT    = 3'd2;
    localparam logic [2:0] ST_WIN    = 3'd3;
    localparam logic [2:0] ST_LOSE   = 3'd4;

    typedef enum logic [2:0] {
        S_INIT   = ST_INIT,
        S_PLAYER = ST_PLAYER,
        S_CAT    = ST_CAT,
        S_WIN    = ST_WIN,
        S_LOSE   = ST_LOSE
    } state_t;

    // Cat step priority: the lowest value is tried first.
    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;
    localparam int NUM_DIRS  = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [MAX_N-1:0][MAX_N-1:0] board_t;

endpackage

// File: rtl/cat_trap_game_fsm_if.sv
// rtl/cat_trap_game_fsm_if.sv - player controls and game status bundle
interface cat_trap_if;
    import cat_trap_pkg::*;

    logic       Start;
    logic       Place;
    idx_t       Sel_Row;
    idx_t       Sel_Col;
    idx_t       Row;
    idx_t       Col;
    logic       Win;
    logic       Lose;
    logic [7:0] Moves;
    logic [2:0] State;

    modport master (
        output Start, Place, Sel_Row, Sel_Col,
        input  Row, Col, Win, Lose, Moves, State
    );

    modport slave (
        input  Start, Place, Sel_Row, Sel_Col,
        output Row, Col, Win, Lose, Moves, State
    );

endinterface

// File: rtl/cat_trap_game_fsm_btn_pulse.sv
// rtl/cat_trap_game_fsm_btn_pulse.sv - raw button to one-cycle pulse; debounce filter under CAT_TRAP_DEBOUNCE_EN
module btn_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [1:0] sync;
    logic       level;
    logic       level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

`ifdef CAT_TRAP_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // Any glitch back to the filtered level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(DEBOUNCE_CYCLES);
    assign level      = sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/cat_trap_game_fsm.sv
// rtl/cat_trap_game_fsm.sv - CatTrap board, cat movement and win/lose FSM; optional CAT_TRAP_DEBOUNCE_EN
module cat_trap_game_fsm
    import cat_trap_pkg::*;
#(
    parameter int          N               = 11,
    parameter int          CAT_R0          = N / 2,
    parameter int          CAT_C0          = N / 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic      Clk,
    input  logic      Reset,
    cat_trap_if.slave game
);

    localparam idx_t LAST = idx_t'(N - 1);

    state_t     state, state_nxt;
    idx_t       row, row_nxt, col, col_nxt;
    idx_t       step_row, step_col, cand_row, cand_col;
    logic [7:0] moves, moves_nxt;
    board_t     board;
    logic       start_p, place_p;
    logic       set_cell, clear_board, place_ok, found, on_edge;

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(Clk), .rst(Reset), .btn(game.Start), .pulse(start_p)
    );

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_place (
        .clk(Clk), .rst(Reset), .btn(game.Place), .pulse(place_p)
    );

    assign place_ok = ({1'b0, game.Sel_Row} < 5'(N)) && ({1'b0, game.Sel_Col} < 5'(N))
                   && !board[game.Sel_Row][game.Sel_Col]
                   && !((game.Sel_Row == row) && (game.Sel_Col == col));

    // The cat is interior whenever CAT is entered, so every neighbour index is in range.
    always_comb begin
        found    = 1'b0;
        step_row = row;
        step_col = col;
        cand_row = row;
        cand_col = col;
        for (int d = 0; d < NUM_DIRS; d++) begin
            cand_row = row;
            cand_col = col;
            case (d)
                DIR_UP:    cand_row = row - 1'b1;
                DIR_RIGHT: cand_col = col + 1'b1;
                DIR_DOWN:  cand_row = row + 1'b1;
                default:   cand_col = col - 1'b1;
            endcase
            if (!found && !board[cand_row][cand_col]) begin
                found    = 1'b1;
                step_row = cand_row;
                step_col = cand_col;
            end
        end
    end

    assign on_edge = (step_row == '0) || (step_row == LAST) || (step_col == '0) || (step_col == LAST);

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        moves_nxt   = moves;
        set_cell    = 1'b0;
        clear_board = 1'b0;
        case (state)
            S_CAT: begin
                if (!found) begin
                    state_nxt = S_WIN;
                end else begin
                    row_nxt   = step_row;
                    col_nxt   = step_col;
                    state_nxt = on_edge ? S_LOSE : S_PLAYER;
                end
            end
            default: begin
                if (start_p) begin
                    clear_board = 1'b1;
                    row_nxt     = idx_t'(CAT_R0);
                    col_nxt     = idx_t'(CAT_C0);
                    moves_nxt   = 8'd0;
                    state_nxt   = S_PLAYER;
                end else if ((state == S_PLAYER) && place_p && place_ok) begin
                    set_cell  = 1'b1;
                    moves_nxt = (moves == 8'hFF) ? moves : moves + 8'd1;
                    state_nxt = S_CAT;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_INIT;
            row   <= idx_t'(CAT_R0);
            col   <= idx_t'(CAT_C0);
            moves <= 8'd0;
            board <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            moves <= moves_nxt;
            if (clear_board) begin
                board <= '0;
            end else if (set_cell) begin
                board[game.Sel_Row][game.Sel_Col] <= 1'b1;
            end
        end
    end

    assign game.Row   = row;
    assign game.Col   = col;
    assign game.Win   = (state == S_WIN);
    assign game.Lose  = (state == S_LOSE);
    assign game.Moves = moves;
    assign game.State = state;

endmodule

// File: tb/tb_cat_trap_game_fsm.sv
// tb/tb_cat_trap_game_fsm.sv - directed and random checks of cat_trap_game_fsm against a board-level model
module tb_cat_trap_game_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cat_trap_if if11 ();
    cat_trap_if if5 ();

    cat_trap_game_fsm #(.N(11), .DEBOUNCE_CYCLES(4)) dut11 (.Clk(clk), .Reset(rst), .game(if11));
    cat_trap_game_fsm #(.N(5),  .DEBOUNCE_CYCLES(4)) dut5  (.Clk(clk), .Reset(rst), .game(if5));

    int n_total = 0;
    int n_pass  = 0;
    int cur     = 0;

    // Reference model: mode 0 idle, 1 playing, 2 trapped, 3 escaped.
    int mn, mode, cr, cc, mv;
    bit blk [16][16];
    int dr [4] = '{-1, 0, 1, 0};
    int dc [4] = '{0, 1, 0, -1};

    task automatic m_clear();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                blk[i][j] = 1'b0;
        cr = mn / 2;
        cc = mn / 2;
        mv = 0;
    endtask

    task automatic m_reset();
        m_clear();
        mode = 0;
    endtask

    task automatic m_start();
        m_clear();
        mode = 1;
    endtask

    function automatic bit m_valid(int r, int c);
        return (mode == 1) && (r < mn) && (c < mn) && !blk[r][c] && !((r == cr) && (c == cc));
    endfunction

    task automatic m_place(int r, int c);
        if (!m_valid(r, c)) return;
        blk[r][c] = 1'b1;
        mv = (mv < 255) ? mv + 1 : 255;
        for (int d = 0; d < 4; d++) begin
            if (!blk[cr + dr[d]][cc + dc[d]]) begin
                cr = cr + dr[d];
                cc = cc + dc[d];
                mode = (cr == 0 || cc == 0 || cr == mn - 1 || cc == mn - 1) ? 3 : 1;
                return;
            end
        end
        mode = 2;
    endtask

    function automatic int exp_state();
        case (mode)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_all(string tag);
        chk({tag, ".row"},   cur ? 32'(if5.Row)   : 32'(if11.Row),   cr);
        chk({tag, ".col"},   cur ? 32'(if5.Col)   : 32'(if11.Col),   cc);
        chk({tag, ".win"},   cur ? 32'(if5.Win)   : 32'(if11.Win),   (mode == 2) ? 1 : 0);
        chk({tag, ".lose"},  cur ? 32'(if5.Lose)  : 32'(if11.Lose),  (mode == 3) ? 1 : 0);
        chk({tag, ".moves"}, cur ? 32'(if5.Moves) : 32'(if11.Moves), mv);
        chk({tag, ".state"}, cur ? 32'(if5.State) : 32'(if11.State), exp_state());
    endtask

    task automatic drive(bit s, bit p, int r, int c);
        if11.Start = s;  if5.Start = s;
        if11.Place = p;  if5.Place = p;
        if11.Sel_Row = 4'(r); if5.Sel_Row = 4'(r);
        if11.Sel_Col = 4'(c); if5.Sel_Col = 4'(c);
    endtask

    // Holds the buttons for four clocks; a valid placement must show CAT one clock after its pulse.
    task automatic press(string tag, bit s, bit p, int r, int c);
        bit valid;
        @(negedge clk);
        drive(s, p, r, c);
        valid = !s && p && m_valid(r, c);
        repeat (3) @(posedge clk);
        #1;
        if (valid) chk({tag, ".cat_state"}, cur ? 32'(if5.State) : 32'(if11.State), 2);
        @(posedge clk);
        #1;
        drive(0, 0, r, c);
        if (s) m_start();
        else if (p) m_place(r, c);
        repeat (3) @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, r, c, d;
        drive(0, 0, 0, 0);
        mn = 11;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset11");
        chk("reset_row_const", if11.Row, 5);

        press("place_in_init", 0, 1, 4, 5);
        press("start", 1, 0, 0, 0);
        press("first_place", 0, 1, 4, 5);
        chk("first_move_row", if11.Row, 5);
        chk("first_move_col", if11.Col, 6);
        press("inv_cat_cell", 0, 1, 5, 6);
        press("inv_blocked", 0, 1, 4, 5);
        press("inv_range", 0, 1, 11, 0);
        chk("inv_moves_const", if11.Moves, 1);

        press("restart", 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) press("escape", 0, 1, 10, 10 - k);
        chk("escape_lose_const", if11.Lose, 1);
        chk("escape_row_const", if11.Row, 0);
        press("place_after_lose", 0, 1, 3, 3);
        press("restart_after_lose", 1, 0, 0, 0);
        chk("restart_lose_const", if11.Lose, 0);

        press("pre_both", 0, 1, 4, 5);
        press("start_and_place", 1, 1, 2, 2);
        chk("both_moves_const", if11.Moves, 0);
        press("reuse_cleared_cell", 0, 1, 4, 5);

        // Reset arriving while the cat is stepping.
        @(negedge clk);
        drive(0, 1, 6, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_cat_state", if11.State, 2);
        rst = 1'b1;
        m_reset();
        #1;
        check_all("reset_in_cat");
        @(negedge clk);
        drive(0, 0, 0, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_all("after_reset_in_cat");

        press("rand_start", 1, 0, 0, 0);
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 6 || (mode >= 2 && sel < 40)) begin
                press("rand_start", 1, 0, 0, 0);
            end else if (sel < 60) begin
                d = $urandom_range(0, 3);
                r = cr + dr[d];
                c = cc + dc[d];
                press("rand_adj", 0, 1, r, c);
            end else begin
                r = $urandom_range(0, 15);
                c = $urandom_range(0, 15);
                press("rand_any", 0, 1, r, c);
            end
        end

        cur = 1;
        mn = 5;
        do_reset();
        press("start5", 1, 0, 0, 0);
        press("trap1", 0, 1, 0, 2);
        press("trap2", 0, 1, 1, 3);
        press("trap3", 0, 1, 1, 1);
        press("trap4", 0, 1, 2, 2);
        chk("trap_win_const", if5.Win, 1);
        chk("trap_row_const", if5.Row, 1);
        chk("trap_col_const", if5.Col, 2);
        chk("trap_moves_const", if5.Moves, 4);
        press("place_after_win", 0, 1, 3, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
